distance_bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter between the ultrasonic distance receiver and the seven-segment digit drivers.
- Accepts a binary distance word on a one-cycle valid strobe and converts it with iterative double-dabble (shift-add-3), one bit per clock.
- Presents DIGITS packed BCD nibbles, one per display digit, so the display shows decimal rather than hex.

---
 rtl/distance_bcd_pkg.sv | 18 +
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/distance_bcd_converter.sv | 144 ++++++++++++++
 tb/tb_distance_bcd_converter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/distance_bcd_pkg.sv
// Shared types and constants for the distance binary-to-BCD converter.
package distance_bcd_pkg;

    localparam int DEF_BIN_WIDTH = 24;
    localparam int DEF_DIGITS    = 6;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
    typedef logic [3:0] bcd_digit_t;

    // Largest value representable with the given number of decimal digits.
    function automatic logic [31:0] bcd_max_value(input int digits);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < digits; i++) v = v * 32'd10;
        return v - 32'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_digit_adjust
    import distance_bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/distance_bcd_converter.sv
// Iterative (one bit per clock) binary-to-BCD converter with a one-deep pending slot.
// Optional leading-zero blanking output enabled by DISTANCE_BCD_BLANK_LEADING_ZERO_EN.
module distance_bcd_converter
    import distance_bcd_pkg::*;
#(
    parameter int BIN_WIDTH = DEF_BIN_WIDTH,
    parameter int DIGITS    = DEF_DIGITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [BIN_WIDTH-1:0]   in_data,
    output logic                   busy,
    output logic                   bcd_valid,
    output logic [4*DIGITS-1:0]    bcd,
    output logic                   overflow
`ifdef DISTANCE_BCD_BLANK_LEADING_ZERO_EN
    ,
    output logic [DIGITS-1:0]      blank
`endif
);

    localparam int          ACC_W     = 4 * DIGITS;
    localparam int          CNT_W     = $clog2(BIN_WIDTH + 1);
    localparam logic [31:0] MAX_VALUE = bcd_max_value(DIGITS);

    state_t                 state, next_state;
    logic [BIN_WIDTH-1:0]   shift_reg;
    logic [ACC_W-1:0]       acc, acc_adj;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf_flag;
    logic [BIN_WIDTH-1:0]   pending_data;
    logic                   pending_full;

    logic                   load;
    logic [BIN_WIDTH-1:0]   load_data;
    logic                   load_over;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (acc[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    assign busy = (state != IDLE);

    // A finishing conversion chains straight into the pending word (or a strobe on that edge).
    always_comb begin
        load      = 1'b0;
        load_data = in_data;
        case (state)
            IDLE: load = in_valid;
            DONE: begin
                load = pending_full || in_valid;
                if (pending_full) load_data = pending_data;
            end
            default: load = 1'b0;
        endcase
        load_over = 32'(load_data) > MAX_VALUE;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = CONVERT;
            CONVERT: if (cnt == '0) next_state = DONE;
            DONE:    next_state = (pending_full || in_valid) ? CONVERT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf_flag  <= 1'b0;
        end else if (load) begin
            shift_reg <= load_data;
            acc       <= '0;
            cnt       <= CNT_W'(BIN_WIDTH - 1);
            ovf_flag  <= load_over;
        end else if (state == CONVERT) begin
            acc       <= {acc_adj[ACC_W-2:0], shift_reg[BIN_WIDTH-1]};
            shift_reg <= {shift_reg[BIN_WIDTH-2:0], 1'b0};
            if (cnt != '0) cnt <= cnt - 1'b1;
            // A bit pushed out of the top digit can only happen when the input exceeds the limit.
            ovf_flag  <= ovf_flag | acc_adj[ACC_W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_full <= 1'b0;
            pending_data <= '0;
        end else if (state == CONVERT && in_valid) begin
            pending_full <= 1'b1;
            pending_data <= in_data;
        end else if (state == DONE && pending_full) begin
            pending_full <= in_valid;
            if (in_valid) pending_data <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_valid <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
        end else begin
            bcd_valid <= (state == DONE);
            if (state == DONE) begin
                bcd      <= ovf_flag ? {DIGITS{4'h9}} : acc;
                overflow <= ovf_flag;
            end
        end
    end

`ifdef DISTANCE_BCD_BLANK_LEADING_ZERO_EN
    logic [DIGITS-1:0] blank_next;
    logic              upper_zero;

    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero    = upper_zero & (acc[4*i +: 4] == 4'd0);
            blank_next[i] = upper_zero & (i != 0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                blank <= '1;
        else if (state == DONE) blank <= ovf_flag ? '0 : blank_next;
    end
`endif

endmodule

// File: tb/tb_distance_bcd_converter.sv
// Scoreboard bench for distance_bcd_converter: directed vectors, monitor pops on bcd_valid.
module tb_distance_bcd_converter;

    localparam int BW = 24;
    localparam int D  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          busy, bcd_valid, overflow;
    logic [4*D-1:0] bcd;
`ifdef DISTANCE_BCD_BLANK_LEADING_ZERO_EN
    logic [D-1:0]  blank;
`endif

    distance_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd       (bcd),
        .overflow  (overflow)
`ifdef DISTANCE_BCD_BLANK_LEADING_ZERO_EN
        ,
        .blank     (blank)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        logic [5:0]  blank;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per bcd_valid pulse.
    exp_t mon_e;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (bcd_valid === 1'b1) begin
            chk("bcd_valid_back_to_back", {31'd0, prev_valid}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bcd_valid: got bcd %0h expected no result (cycle %0d)", bcd, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("bcd", {8'd0, bcd}, {8'd0, mon_e.bcd});
                chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
                if (mon_e.cyc >= 0) chk("latency_cycle", cyc, mon_e.cyc);
`ifdef DISTANCE_BCD_BLANK_LEADING_ZERO_EN
                chk("blank", {26'd0, blank}, {26'd0, mon_e.blank});
`endif
            end
        end
        prev_valid = bcd_valid;
    end

    // Assumes the caller is at a falling edge; the strobe is sampled on the next rising edge.
    task automatic strobe(input logic [BW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_exp(input logic [BW-1:0] d, input logic [23:0] eb, input logic eo,
                            input logic [5:0] ebl, input bit lat);
        exp_t e;
        @(negedge clk);
        e.bcd   = eb;
        e.ovf   = eo;
        e.blank = ebl;
        e.cyc   = lat ? cyc + BW + 2 : -1;
        q.push_back(e);
        strobe(d);
    endtask

    task automatic push_exp(input logic [23:0] eb, input logic [5:0] ebl, input int ec);
        exp_t e;
        e.bcd   = eb;
        e.ovf   = 1'b0;
        e.blank = ebl;
        e.cyc   = ec;
        q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, (q.size() != 0 || busy)}, 32'd0);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_bcd", {8'd0, bcd}, 32'd0);
        chk("reset_bcd_valid", {31'd0, bcd_valid}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef DISTANCE_BCD_BLANK_LEADING_ZERO_EN
        chk("reset_blank", {26'd0, blank}, 32'h3f);
`endif
        rst = 1'b0;

        send_exp(24'd123456, 24'h123456, 1'b0, 6'b000000, 1'b1);
        chk("busy_during_convert", {31'd0, busy}, 32'd1);
        wait_done(80);

        send_exp(24'd0,       24'h000000, 1'b0, 6'b111110, 1'b1);
        wait_done(80);
        send_exp(24'd999999,  24'h999999, 1'b0, 6'b000000, 1'b1);
        wait_done(80);
        send_exp(24'd1000000, 24'h999999, 1'b1, 6'b000000, 1'b1);
        wait_done(80);
        send_exp(24'hFFFFFF,  24'h999999, 1'b1, 6'b000000, 1'b1);
        wait_done(80);
        send_exp(24'd42,      24'h000042, 1'b0, 6'b111100, 1'b1);
        wait_done(80);

        // 5, then 7 three cycles later, then 9 four cycles after that: 7 is overwritten.
        @(negedge clk);
        base = cyc;
        push_exp(24'h000005, 6'b111110, base + BW + 2);
        push_exp(24'h000009, 6'b111110, base + 2 * BW + 3);
        strobe(24'd5);
        repeat (2) @(negedge clk);
        strobe(24'd7);
        repeat (3) @(negedge clk);
        strobe(24'd9);
        wait_done(120);

        // Reset ten cycles into a conversion with a word pending: nothing may come out.
        @(negedge clk);
        strobe(24'd4321);
        repeat (2) @(negedge clk);
        strobe(24'd88);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_bcd", {8'd0, bcd}, 32'd0);
        chk("midreset_overflow", {31'd0, overflow}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_bcd_valid", {31'd0, bcd_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("after_reset_idle", {31'd0, busy}, 32'd0);

        send_exp(24'd55, 24'h000055, 1'b0, 6'b111100, 1'b1);
        wait_done(80);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
